// File: rtl/cpu6_bus_responder_pkg.sv
// Shared types and constants for the CPU6 bus responder: serializer states,
// console status bit positions and the value returned for unmapped reads.
package cpu6_bus_pkg;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_t;

   localparam int RX_READY    = 0;
   localparam int TX_NOT_FULL = 1;
   localparam int TX_OVF      = 2;
   localparam int RX_OVR      = 3;

   localparam logic [7:0] UNMAPPED_READ = 8'hFF;

endpackage

// File: rtl/cpu6_bus_responder_if.sv
// CPU6 memory bus as seen by the responder: address, write data, write strobe
// and registered read data.
interface cpu6_bus_if;
   import cpu6_bus_pkg::*;

   logic [15:0] address;
   logic [7:0]  data_in;
   logic        write_en;
   logic [7:0]  data_out;

   modport master (output address, data_in, write_en, input data_out);
   modport slave  (input address, data_in, write_en, output data_out);
endinterface

// File: rtl/cpu6_bus_responder_fifo.sv
// Synchronous TX FIFO; FIFO_DEPTH is a power of two (>= 2) so the pointers
// wrap by plain binary overflow.
module cpu6_tx_fifo
   import cpu6_bus_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push;
   logic              do_pop;

   // A push into a full FIFO is dropped even when a pop happens the same cycle.
   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cpu6_bus_responder.sv
// CPU6 bus responder: local RAM, console status/data registers, TX FIFO and an
// 8N1 serializer driving txd.
module cpu6_bus_responder
   import cpu6_bus_pkg::*;
#(
   parameter int          RAM_ADDR_BITS = 12,
   parameter logic [15:0] MMIO_BASE     = 16'hF200,
   parameter int          BAUD_DIV      = 16,
   parameter int          FIFO_DEPTH    = 4
) (
   input  logic       clock,
   input  logic       reset,
   cpu6_bus_if.slave  bus,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       txd,
   output logic       tx_busy
);
   localparam int BAUD_W = $clog2(BAUD_DIV);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

   logic [7:0] ram [2**RAM_ADDR_BITS];
   logic [7:0] rx_hold;
   logic       rx_ready;
   logic       rx_overrun;
   logic       tx_overflow;
   logic [7:0] status;
   logic [7:0] rd_data_p0;
   logic       ram_hit;
   logic       stat_hit;
   logic       data_hit;
   logic       stat_wr;
   logic       data_wr;

   logic       fifo_pop;
   logic [7:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;

   ser_state_t        state, state_nxt;
   logic [BAUD_W-1:0] baud_cnt, baud_nxt;
   logic [2:0]        bit_cnt, bit_nxt;
   logic [7:0]        shift_reg, shift_nxt;

   assign ram_hit  = ((bus.address >> RAM_ADDR_BITS) == 16'd0);
   assign stat_hit = (bus.address == MMIO_BASE);
   assign data_hit = (bus.address == MMIO_BASE + 16'd1);
   assign stat_wr  = bus.write_en && stat_hit;
   assign data_wr  = bus.write_en && data_hit;

   always_comb begin
      status              = 8'h00;
      status[RX_READY]    = rx_ready;
      status[TX_NOT_FULL] = !fifo_full;
      status[TX_OVF]      = tx_overflow;
      status[RX_OVR]      = rx_overrun;
   end

   // Stage p0: read decode from the pre-edge RAM contents, which makes a
   // same-cycle write to the read address return the old byte.
   always_comb begin
      rd_data_p0 = UNMAPPED_READ;
      if (ram_hit)       rd_data_p0 = ram[bus.address[RAM_ADDR_BITS-1:0]];
      else if (stat_hit) rd_data_p0 = status;
      else if (data_hit) rd_data_p0 = rx_hold;
   end

   // Stage p1: registered read data to the CPU.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) bus.data_out <= 8'h00;
      else       bus.data_out <= rd_data_p0;
   end

   always_ff @(posedge clock) begin
      if (bus.write_en && ram_hit) ram[bus.address[RAM_ADDR_BITS-1:0]] <= bus.data_in;
      if (rx_valid) rx_hold <= rx_data;
   end

   // Later assignments win, so a new RX byte beats a same-cycle clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_ready    <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (stat_wr && bus.data_in[RX_READY]) rx_ready    <= 1'b0;
         if (stat_wr && bus.data_in[RX_OVR])   rx_overrun  <= 1'b0;
         if (stat_wr && bus.data_in[TX_OVF])   tx_overflow <= 1'b0;
         if (data_wr && fifo_full)             tx_overflow <= 1'b1;
         if (rx_valid) begin
            rx_ready <= 1'b1;
            if (rx_ready) rx_overrun <= 1'b1;
         end
      end
   end

   cpu6_tx_fifo #(
      .DATA_W     (8),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (data_wr),
      .push_data (bus.data_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= SER_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
      end
   end

   always_ff @(posedge clock) begin
      shift_reg <= shift_nxt;
   end

   // txd decodes straight from state so an asynchronous reset idles the line at once.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift_reg;
      fifo_pop  = 1'b0;
      txd       = 1'b1;
      case (state)
         SER_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_nxt = fifo_dout;
               baud_nxt  = BAUD_LAST;
               state_nxt = SER_START;
            end
         end
         SER_START: begin
            txd = 1'b0;
            if (baud_cnt == '0) begin
               baud_nxt  = BAUD_LAST;
               bit_nxt   = 3'd0;
               state_nxt = SER_DATA;
            end else begin
               baud_nxt = baud_cnt - 1'b1;
            end
         end
         SER_DATA: begin
            txd = shift_reg[0];
            if (baud_cnt == '0) begin
               baud_nxt  = BAUD_LAST;
               shift_nxt = {1'b0, shift_reg[7:1]};
               bit_nxt   = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nxt = SER_STOP;
            end else begin
               baud_nxt = baud_cnt - 1'b1;
            end
         end
         SER_STOP: begin
            if (baud_cnt == '0) state_nxt = SER_IDLE;
            else                baud_nxt  = baud_cnt - 1'b1;
         end
         default: state_nxt = SER_IDLE;
      endcase
   end

   assign tx_busy = (state != SER_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cpu6_bus_responder.sv
// Scoreboard bench for cpu6_bus_responder: a cycle-level behavioural model
// predicts data_out/txd/tx_busy, a monitor compares them on each falling edge.
module tb_cpu6_bus_responder;
   import cpu6_bus_pkg::*;

   localparam int          BD    = 4;
   localparam int          DEPTH = 4;
   localparam int          RAB   = 12;
   localparam logic [15:0] MB    = 16'hF200;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       txd;
   logic       tx_busy;

   cpu6_bus_if bus ();

   cpu6_bus_responder #(
      .RAM_ADDR_BITS (RAB),
      .MMIO_BASE     (MB),
      .BAUD_DIV      (BD),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus.slave),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .txd      (txd),
      .tx_busy  (tx_busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] dout;
      bit         dchk;
      logic       txd;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: memory map contents, console flags, FIFO as a
   // queue and the serializer as "cycles left in the current 10-bit frame".
   logic [7:0] mem [int];
   bit         m_rdy, m_ovf, m_ovr;
   logic [7:0] m_hold;
   bit         m_hold_known = 0;
   logic [7:0] m_fifo[$];
   int         m_ser_cnt;
   logic [7:0] m_ser_byte;

   function automatic logic model_txd();
      int e, slot;
      if (m_ser_cnt == 0) return 1'b1;
      e    = 10 * BD - m_ser_cnt;
      slot = e / BD;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_ser_byte[slot-1];
      return 1'b1;
   endfunction

   function automatic bit model_busy();
      return (m_ser_cnt > 0) || (m_fifo.size() > 0);
   endfunction

   task automatic model_reset();
      m_rdy = 0; m_ovf = 0; m_ovr = 0;
      m_fifo.delete();
      m_ser_cnt = 0;
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // One bus cycle: drive inputs, advance the model across the edge, then
   // hand the post-edge expectation to the monitor.
   task automatic step(input logic [15:0] a, input logic [7:0] d, input logic we,
                       input logic rxv, input logic [7:0] rxd);
      exp_t e;
      bit   full_pre, rdy_pre;
      bus.address = a; bus.data_in = d; bus.write_en = we;
      rx_valid = rxv; rx_data = rxd;
      e.dchk = 1;
      if (int'(a) < 2**RAB) begin
         if (mem.exists(int'(a))) e.dout = mem[int'(a)];
         else begin e.dout = 8'h00; e.dchk = 0; end
      end else if (a == MB) begin
         e.dout = {4'b0, m_ovr, m_ovf, (m_fifo.size() < DEPTH), m_rdy};
      end else if (a == MB + 16'd1) begin
         e.dout = m_hold; e.dchk = m_hold_known;
      end else begin
         e.dout = 8'hFF;
      end
      full_pre = (m_fifo.size() == DEPTH);
      rdy_pre  = m_rdy;
      if (m_ser_cnt > 0) m_ser_cnt--;
      else if (m_fifo.size() > 0) begin
         m_ser_byte = m_fifo.pop_front();
         m_ser_cnt  = 10 * BD;
      end
      if (we && a == MB + 16'd1) begin
         if (full_pre) m_ovf = 1;
         else m_fifo.push_back(d);
      end
      if (we && a == MB) begin
         if (d[0]) m_rdy = 0;
         if (d[2]) m_ovf = 0;
         if (d[3]) m_ovr = 0;
      end
      if (rxv) begin
         if (rdy_pre) m_ovr = 1;
         m_rdy = 1; m_hold = rxd; m_hold_known = 1;
      end
      if (we && int'(a) < 2**RAB) mem[int'(a)] = d;
      e.txd  = model_txd();
      e.busy = model_busy();
      @(posedge clock);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic reset_step();
      exp_t e;
      e.dout = 8'h00; e.dchk = 1; e.txd = 1'b1; e.busy = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(MB, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.dchk) check("data_out", bus.data_out, e.dout);
            check("txd", {7'b0, txd}, {7'b0, e.txd});
            check("tx_busy", {7'b0, tx_busy}, {7'b0, e.busy});
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : driver
      exp_t e;
      logic [15:0] a;
      bus.address = 16'h0000; bus.data_in = 8'h00; bus.write_en = 1'b0;
      model_reset();
      reset_step();
      reset_step();
      reset = 1'b0;

      // RAM write/read, read-first and unmapped reads
      step(16'h0123, 8'hA5, 1'b1, 1'b0, 8'h00);
      step(16'h0123, 8'h00, 1'b0, 1'b0, 8'h00);
      step(16'h0123, 8'h5A, 1'b1, 1'b0, 8'h00);
      step(16'h0123, 8'h00, 1'b0, 1'b0, 8'h00);
      step(16'h8000, 8'h00, 1'b0, 1'b0, 8'h00);
      step(16'h0FFF, 8'h3E, 1'b1, 1'b0, 8'h00);
      step(16'h0FFF, 8'h00, 1'b0, 1'b0, 8'h00);
      step(16'h1000, 8'h77, 1'b1, 1'b0, 8'h00);
      step(16'hF202, 8'h00, 1'b0, 1'b0, 8'h00);

      // RX ready, overrun, write-1-to-clear, set-wins-over-clear
      step(MB, 8'h00, 1'b0, 1'b1, 8'h41);
      step(MB, 8'h00, 1'b0, 1'b0, 8'h00);
      step(MB + 16'd1, 8'h00, 1'b0, 1'b0, 8'h00);
      step(MB, 8'h00, 1'b0, 1'b1, 8'h42);
      step(MB + 16'd1, 8'h00, 1'b0, 1'b0, 8'h00);
      step(MB, 8'h09, 1'b1, 1'b0, 8'h00);
      step(MB, 8'h00, 1'b0, 1'b0, 8'h00);
      step(MB, 8'h00, 1'b0, 1'b1, 8'h17);
      step(MB, 8'h01, 1'b1, 1'b1, 8'h18);
      step(MB, 8'h0B, 1'b1, 1'b0, 8'h00);
      idle(2);

      // Single frame of 0x55
      step(MB + 16'd1, 8'h55, 1'b1, 1'b0, 8'h00);
      idle(45);

      // Six back-to-back writes: one pops, four queue, the sixth overflows
      for (int i = 0; i < 6; i++) step(MB + 16'd1, 8'(8'h10 + i * 8'h11), 1'b1, 1'b0, 8'h00);
      idle(5 * (10 * BD + 1) + 5);
      step(MB, 8'h04, 1'b1, 1'b0, 8'h00);
      idle(2);

      // Reset in the middle of the data bits
      step(MB + 16'd1, 8'h3C, 1'b1, 1'b0, 8'h00);
      step(MB + 16'd1, 8'hC3, 1'b1, 1'b0, 8'h00);
      idle(20);
      reset = 1'b1;
      #1;
      check("reset_txd", {7'b0, txd}, 8'h01);
      check("reset_busy", {7'b0, tx_busy}, 8'h00);
      check("reset_data_out", bus.data_out, 8'h00);
      model_reset();
      exp_q.delete();
      e.dout = 8'h00; e.dchk = 1; e.txd = 1'b1; e.busy = 1'b0;
      exp_q.push_back(e);
      reset_step();
      reset_step();
      reset = 1'b0;
      idle(100);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 16'($urandom_range(0, 15));
            4, 5:       a = MB;
            6, 7:       a = MB + 16'd1;
            8:          a = 16'($urandom);
            default:    a = 16'h1000 + 16'($urandom_range(0, 255));
         endcase
         step(a, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
              8'($urandom));
      end
      idle(10 * BD * (DEPTH + 1) + 10);

      @(negedge clock);
      @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu6_bus_responder.md
Name: cpu6_bus_responder

Overview:
- Bus-side responder for the CPU6 memory bus. It answers the CPU's address/data/write-enable cycles with local RAM and a memory-mapped console port.
- The console port is a TX FIFO feeding an 8N1 serializer, plus a single-byte RX holding register.
- It sits between the CPU6 core and the board pins. CPU dataOutBus drives data_in; data_out drives the CPU's dataInBus.

Parameters:
- RAM_ADDR_BITS, 12: RAM occupies 0x0000 .. 2^RAM_ADDR_BITS-1.
- MMIO_BASE, 16'hF200: console status register at MMIO_BASE, data register at MMIO_BASE+1.
- BAUD_DIV, 16: clocks per serial bit. Must be >= 2.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- address  in  16  CPU memory address
- data_in  in  8  CPU write data
- write_en  in  1  CPU write strobe, sampled at the rising edge
- data_out  out  8  registered read data to the CPU
- rx_data  in  8  received byte from the external deserializer
- rx_valid  in  1  single-cycle strobe: rx_data is valid
- txd  out  1  serial transmit line, idle high
- tx_busy  out  1  serializer not idle, or FIFO not empty

Behaviour:
- Reset: asynchronous, active-high. Clock: clock. Reset values:
  - data_out=0x00, txd=1, tx_busy=0
  - FIFO empty, pointers 0; serializer IDLE
  - RX ready/overrun/TX overflow flags all 0
  - RAM contents not reset.
- Read latency: 1 cycle. At each posedge, data_out is loaded from the current address:
  - address < 2^RAM_ADDR_BITS: RAM[address].
  - address == MMIO_BASE: status = {4'b0, rx_overrun, tx_overflow, fifo_not_full, rx_ready}.
  - address == MMIO_BASE+1: RX holding register.
  - Any other address: 0xFF.
- Reads have no side effects.
- Write, at a posedge with write_en=1:
  - RAM address: RAM[address] <= data_in.
  - Same-cycle read of that address returns the old data (read-first).
  - Data register: push data_in if the FIFO is not full. If full, drop the byte and set tx_overflow (sticky).
  - Status register: write-1-to-clear. Bit0 clears rx_ready, bit2 clears tx_overflow, bit3 clears rx_overrun.
  - Unmapped addresses and writes to bits 1/7:4: ignored.
- RX, rx_valid=1:
  - Holding register <= rx_data; rx_ready <= 1.
  - If rx_ready was already 1, also set rx_overrun. The new byte overwrites the old one.
  - rx_valid together with a clear of bit0 in the same cycle: set wins, so rx_ready=1.
- FIFO:
  - Simultaneous push and pop is legal at any occupancy except full-with-push. Full-with-push drops the byte even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if FIFO non-empty, pop into the shift register and go to START on the next edge.
  - START: txd=0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB-first, BAUD_DIV cycles each; 3-bit bit counter.
  - STOP: txd=1 for BAUD_DIV cycles, then IDLE. Back-to-back bytes add exactly 1 idle cycle.
  - Baud counter reloads on every state/bit change.
- tx_busy = (state != IDLE) || FIFO non-empty. Combinational from registers.
- Reset asserted mid-frame: txd returns to 1 immediately and the FIFO is flushed.

Decomposition:
- Shared package cpu6_bus_pkg:
  - Serializer state enum.
  - Status bit index constants (RX_READY=0, TX_NOT_FULL=1, TX_OVF=2, RX_OVR=3).
  - UNMAPPED_READ=8'hFF.
- One sub-module: cpu6_tx_fifo (parameterised sync FIFO with push/pop/full/empty). RAM, decode and serializer stay in the top.

Test Plan:
- Write 0xA5 to 0x0123, then hold address 0x0123 -> data_out=0xA5 one cycle later. Address 0x8000 -> data_out=0xFF.
- Read of MMIO_BASE after reset -> 0x02. Inject rx_valid with rx_data=0x41 -> status=0x03 and MMIO_BASE+1 reads 0x41.
- Second rx_valid (0x42) without clearing -> status=0x0B, data=0x42. Write 0x09 to MMIO_BASE -> status=0x02.
- With BAUD_DIV=4, write 0x55 to MMIO_BASE+1:
  - txd low for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles.
  - tx_busy falls after the stop bit.
- Write 6 bytes back-to-back with FIFO_DEPTH=4:
  - First pops into the serializer; the sixth write drops; status bit2=1.
  - 5 frames emitted in order. Write 0x04 to status -> bit2=0.
- Assert reset mid-DATA -> txd=1 and tx_busy=0 immediately. No further frames after release.
